// File: rtl/adder_sweep_checker_if.sv
// Vector bus carrying one adder stimulus/response pair per cycle from the
// sweep driver to the response checker.
interface adder_sweep_checker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output in_valid, a, b, cin, sum, cout);
  modport slave  (input  in_valid, a, b, cin, sum, cout);
endinterface

// File: rtl/adder_sweep_checker.sv
// Response checker for an exhaustive WIDTH-bit adder sweep: checks every
// vector against a reference sum and the sweep order, then reports a verdict.
module adder_sweep_checker #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  adder_sweep_checker_if.slave   vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2*WIDTH+1:0]     err_count,
  output logic                   first_err_valid,
  output logic [2*WIDTH:0]       first_err_idx,
  output logic                   seq_err
);

  localparam int IDXW = 2*WIDTH + 1;
  localparam int ERRW = 2*WIDTH + 2;
  localparam logic [IDXW-1:0] IDX_LAST = {IDXW{1'b1}};
  localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              clear_s;
  logic              accept_s;
  logic              mismatch_s;
  logic              order_bad_s;
  logic              busy_r;
  logic              done_r;
  logic [IDXW-1:0]   idx_r;
  logic [ERRW-1:0]   err_count_r;
  logic              first_err_valid_r;
  logic [IDXW-1:0]   first_err_idx_r;
  logic              seq_err_r;

  // Full-precision reference sum; the carry lands in the top bit.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] op_a,
                                             input logic [WIDTH-1:0] op_b,
                                             input logic             op_c);
    return {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_c};
  endfunction

  // Next-state decode and per-cycle strobes.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (vec.in_valid) begin
          accept_s = 1'b1;
          if (idx_r == IDX_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign mismatch_s  = accept_s && ({vec.cout, vec.sum} != ref_sum(vec.a, vec.b, vec.cin));
  assign order_bad_s = accept_s && ({vec.cin, vec.b, vec.a} != idx_r);

  // State register with busy/done registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Sweep index, error counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      idx_r             <= {IDXW{1'b0}};
      err_count_r       <= {ERRW{1'b0}};
      first_err_valid_r <= 1'b0;
      first_err_idx_r   <= {IDXW{1'b0}};
      seq_err_r         <= 1'b0;
    end else if (accept_s) begin
      // The last vector leaves idx parked rather than wrapping.
      if (idx_r != IDX_LAST) begin
        idx_r <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
      end
      if (mismatch_s && (err_count_r != ERR_MAX)) begin
        err_count_r <= err_count_r + {{(ERRW-1){1'b0}}, 1'b1};
      end
      if (mismatch_s && !first_err_valid_r) begin
        first_err_valid_r <= 1'b1;
        first_err_idx_r   <= idx_r;
      end
      if (order_bad_s) begin
        seq_err_r <= 1'b1;
      end
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = done_r && (err_count_r == {ERRW{1'b0}}) && !seq_err_r;
  assign err_count       = err_count_r;
  assign first_err_valid = first_err_valid_r;
  assign first_err_idx   = first_err_idx_r;
  assign seq_err         = seq_err_r;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Directed-plus-random bench for adder_sweep_checker with an integer-level
// model of the expected verdict for each sweep.
module tb_adder_sweep_checker;

  localparam int W      = 4;
  localparam int N      = 1 << (2*W + 1);
  localparam int MASK   = (1 << W) - 1;
  localparam int ERRMAX = (1 << (2*W + 2)) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic           pass;
  logic [2*W+1:0] err_count;
  logic           first_err_valid;
  logic [2*W:0]   first_err_idx;
  logic           seq_err;

  adder_sweep_checker_if #(.WIDTH(W)) vif ();

  adder_sweep_checker #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .vec             (vif),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .seq_err         (seq_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int m_err;
  int m_fei;
  bit m_fev;
  bit m_seq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_err = 0;
    m_fei = 0;
    m_fev = 1'b0;
    m_seq = 1'b0;
  endtask

  task automatic check_status(input string tag, input int exp_busy, input int exp_done);
    int exp_pass;
    exp_pass = (exp_done == 1 && m_err == 0 && !m_seq) ? 1 : 0;
    check({tag, "_busy"}, int'(busy), exp_busy);
    check({tag, "_done"}, int'(done), exp_done);
    check({tag, "_pass"}, int'(pass), exp_pass);
    check({tag, "_err_count"}, int'(err_count), m_err);
    check({tag, "_first_err_valid"}, int'(first_err_valid), int'(m_fev));
    check({tag, "_first_err_idx"}, int'(first_err_idx), m_fei);
    check({tag, "_seq_err"}, int'(seq_err), int'(m_seq));
  endtask

  task automatic drive_random(input bit valid);
    vif.in_valid = valid;
    vif.a        = W'($urandom);
    vif.b        = W'($urandom);
    vif.cin      = 1'($urandom);
    vif.sum      = W'($urandom);
    vif.cout     = 1'($urandom);
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      drive_random(1'b0);
      tick();
    end
  endtask

  task automatic pulse_start(input string tag);
    drive_random(1'($urandom_range(0, 1)));
    start = 1'b1;
    tick();
    start        = 1'b0;
    vif.in_valid = 1'b0;
    model_clear();
    check_status(tag, 1, 0);
  endtask

  // Drives one sweep; position k normally carries sweep index k.
  task automatic sweep(input string tag, input int inject_idx, input int swap_at,
                       input bit zero_sum, input int gap_mode, input bit rand_err,
                       input int stop_after, input int start_mid);
    int k = 0;
    while (k < N) begin
      int s;
      int av;
      int bv;
      int cv;
      int exp_v;
      int res;
      if (k == stop_after) return;
      if (gap_mode == 2 && $urandom_range(0, 3) == 0) idle_noise($urandom_range(1, 2));
      if (k == N - 1) begin
        check({tag, "_busy_before_last"}, int'(busy), 1);
        check({tag, "_done_before_last"}, int'(done), 0);
      end
      s     = (k == swap_at) ? k + 1 : k;
      av    = s & MASK;
      bv    = (s >> W) & MASK;
      cv    = (s >> (2*W)) & 1;
      exp_v = av + bv + cv;
      res   = zero_sum ? (exp_v & (1 << W)) : exp_v;
      if (k == inject_idx) res = res ^ 1;
      if (rand_err && $urandom_range(0, 15) == 0) res = res ^ (1 << $urandom_range(0, W));
      vif.in_valid = 1'b1;
      vif.a        = av[W-1:0];
      vif.b        = bv[W-1:0];
      vif.cin      = cv[0];
      vif.sum      = res[W-1:0];
      vif.cout     = res[W];
      start        = (k == start_mid);
      tick();
      start        = 1'b0;
      vif.in_valid = 1'b0;
      if (res != exp_v) begin
        if (m_err < ERRMAX) m_err++;
        if (!m_fev) begin
          m_fev = 1'b1;
          m_fei = k;
        end
      end
      if (s != k) m_seq = 1'b1;
      k++;
      if (gap_mode == 1 && k % 10 == 0) idle_noise(3);
    end
    check_status(tag, 0, 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    vif.in_valid = 1'b0;
    vif.a = '0; vif.b = '0; vif.cin = 1'b0; vif.sum = '0; vif.cout = 1'b0;
    model_clear();
    tick();
    tick();
    check_status("reset", 0, 0);
    rst = 1'b0;

    // Bad vectors while idle must not be counted.
    vif.in_valid = 1'b1; vif.a = 4'd1; vif.b = 4'd1; vif.sum = 4'd0; vif.cout = 1'b0;
    tick(); tick(); tick();
    vif.in_valid = 1'b0;
    check_status("idle_ignore", 0, 0);

    pulse_start("start_clean");
    sweep("clean", -1, -1, 1'b0, 0, 1'b0, -1, -1);
    check("clean_pass_const", int'(pass), 1);

    vif.in_valid = 1'b1; vif.a = 4'd3; vif.b = 4'd3; vif.sum = 4'd0; vif.cout = 1'b1;
    tick(); tick();
    vif.in_valid = 1'b0;
    check_status("done_ignore", 0, 1);

    pulse_start("start_inject");
    sweep("inject37", 37, -1, 1'b0, 0, 1'b0, -1, -1);
    check("inject37_idx_const", int'(first_err_idx), 37);
    check("inject37_cnt_const", int'(err_count), 1);

    pulse_start("start_order");
    sweep("order", -1, 5, 1'b0, 0, 1'b0, -1, -1);
    check("order_seq_const", int'(seq_err), 1);

    pulse_start("start_gap");
    sweep("gap_randerr", -1, -1, 1'b0, 1, 1'b1, -1, -1);

    pulse_start("start_zero");
    sweep("zero_sum", -1, -1, 1'b1, 0, 1'b0, -1, -1);
    check("zero_sum_first_idx_const", int'(first_err_idx), 1);

    // Restart from a failing DONE, with a stray start mid-run.
    pulse_start("restart_from_done");
    sweep("restart_clean", -1, -1, 1'b0, 0, 1'b0, -1, 200);

    pulse_start("start_midrst");
    sweep("midrst_part", -1, -1, 1'b0, 2, 1'b1, 100, -1);
    drive_random(1'b1);
    start = 1'($urandom_range(0, 1));
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    vif.in_valid = 1'b0;
    model_clear();
    check_status("midrst", 0, 0);

    pulse_start("start_after_rst");
    sweep("after_rst_clean", -1, -1, 1'b0, 2, 1'b0, -1, -1);

    pulse_start("start_rand");
    sweep("rand_gaps_err", -1, -1, 1'b0, 2, 1'b1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
